// File: rtl/treasure_classifier_if.sv
// rtl/treasure_classifier_if.sv - pixel read stream in, classification result out
interface treasure_classifier_if;
   logic [15:0] PIXEL_IN;
   logic [9:0]  VGA_PIXEL_X;
   logic [9:0]  VGA_PIXEL_Y;
   logic [1:0]  COLOR;
   logic [1:0]  SHAPE;
   logic        RESULT_VALID;

   modport master (
      output PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y,
      input  COLOR, SHAPE, RESULT_VALID
   );

   modport slave (
      input  PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y,
      output COLOR, SHAPE, RESULT_VALID
   );
endinterface

// File: rtl/treasure_classifier.sv
// rtl/treasure_classifier.sv - frame-level colour/shape classifier on the VGA read side
module treasure_classifier #(
   parameter int SCREEN_WIDTH  = 176,
   parameter int SCREEN_HEIGHT = 144,
   parameter int ROW_STEP      = 12,
   parameter int COUNT_THRESH  = 200,
   parameter int WIDTH_TOL     = 3,
   parameter int TREND_MIN     = 3
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   treasure_classifier_if.slave bus
);
   localparam logic [9:0]         X_LIM  = 10'(SCREEN_WIDTH);
   localparam logic [9:0]         X_LAST = 10'(SCREEN_WIDTH - 1);
   localparam logic [9:0]         Y_LIM  = 10'(SCREEN_HEIGHT);
   localparam logic [9:0]         STEP   = 10'(ROW_STEP);
   localparam logic [14:0]        THRESH = 15'(COUNT_THRESH);
   localparam logic signed [8:0]  TOL    = 9'(WIDTH_TOL);
   localparam logic [4:0]         TMIN   = 5'(TREND_MIN);

   typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;
   state_t state_q, state_d;

   logic [9:0]  px_q, py_q;
   logic [14:0] red_cnt_q, red_cnt_d, blue_cnt_q, blue_cnt_d;
   logic [7:0]  row_w_q, row_w_d, prev_w_q, prev_w_d;
   logic [4:0]  inc_q, inc_d, dec_q, dec_d, flat_q, flat_d;
   logic        row_end_q, row_end_d;
   logic [1:0]  color_q, color_d, shape_q, shape_d;
   logic        valid_q, valid_d;

   logic        frame_start, frame_end, clear, active, in_win, sampled, is_red, is_blue;
   logic        inc_hit, dec_hit;
   logic signed [8:0] delta;
   logic [1:0]  dec_color, dec_shape;

   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v == 5'd31) ? v : v + 5'd1;
   endfunction

   // px/py line up with PIXEL_IN, which returns one cycle after the address
   assign frame_start = (px_q == 10'd0) && (py_q == 10'd0);
   assign frame_end   = (py_q == Y_LIM);
   assign clear       = frame_start && (state_q != DECIDE);
   assign active      = (state_q == ACCUM) || clear;
   assign in_win      = (px_q < X_LIM) && (py_q < Y_LIM);
   assign sampled     = (py_q % STEP) == 10'd0;
   assign is_red      = (bus.PIXEL_IN == 16'hF800);
   assign is_blue     = (bus.PIXEL_IN == 16'h001F);
   assign delta       = $signed({1'b0, row_w_q}) - $signed({1'b0, prev_w_q});

   always_ff @(posedge CLOCK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_start) state_d = ACCUM;
         ACCUM:   if (frame_end)   state_d = DECIDE;
         DECIDE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      red_cnt_d  = red_cnt_q;
      blue_cnt_d = blue_cnt_q;
      row_w_d    = row_w_q;
      prev_w_d   = prev_w_q;
      inc_d      = inc_q;
      dec_d      = dec_q;
      flat_d     = flat_q;
      row_end_d  = 1'b0;
      if (clear) begin
         red_cnt_d  = '0;
         blue_cnt_d = '0;
         row_w_d    = '0;
         prev_w_d   = '0;
         inc_d      = '0;
         dec_d      = '0;
         flat_d     = '0;
      end else if ((state_q == ACCUM) && row_end_q) begin
         // an empty row stores prev_w=0, which breaks the trend chain
         if ((row_w_q != 8'd0) && (prev_w_q != 8'd0)) begin
            if (delta > TOL)       inc_d  = sat_inc(inc_q);
            else if (delta < -TOL) dec_d  = sat_inc(dec_q);
            else                   flat_d = sat_inc(flat_q);
         end
         prev_w_d = row_w_q;
         row_w_d  = '0;
      end
      if (active && in_win) begin
         if (is_red)  red_cnt_d  = red_cnt_d + 15'd1;
         if (is_blue) blue_cnt_d = blue_cnt_d + 15'd1;
         if (sampled && (is_red || is_blue)) row_w_d = row_w_d + 8'd1;
         row_end_d = sampled && (px_q == X_LAST);
      end
   end

   always_comb begin
      dec_color = 2'b00;
      if ((red_cnt_q >= THRESH) && (red_cnt_q > blue_cnt_q))       dec_color = 2'b01;
      else if ((blue_cnt_q >= THRESH) && (blue_cnt_q > red_cnt_q)) dec_color = 2'b10;
      inc_hit   = (inc_q >= TMIN);
      dec_hit   = (dec_q >= TMIN);
      dec_shape = 2'b00;
      if (dec_color != 2'b00) begin
         if (inc_hit && dec_hit)      dec_shape = 2'b10;
         else if (inc_hit || dec_hit) dec_shape = 2'b01;
         else if (flat_q >= TMIN)     dec_shape = 2'b11;
      end
   end

   // results are loaded on the ACCUM->DECIDE edge so they are valid during DECIDE
   always_comb begin
      valid_d = (state_q == ACCUM) && frame_end;
      color_d = valid_d ? dec_color : color_q;
      shape_d = valid_d ? dec_shape : shape_q;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         px_q       <= 10'h3FF;
         py_q       <= 10'h3FF;
         red_cnt_q  <= '0;
         blue_cnt_q <= '0;
         row_w_q    <= '0;
         prev_w_q   <= '0;
         inc_q      <= '0;
         dec_q      <= '0;
         flat_q     <= '0;
         row_end_q  <= 1'b0;
         color_q    <= 2'b00;
         shape_q    <= 2'b00;
         valid_q    <= 1'b0;
      end else begin
         px_q       <= bus.VGA_PIXEL_X;
         py_q       <= bus.VGA_PIXEL_Y;
         red_cnt_q  <= red_cnt_d;
         blue_cnt_q <= blue_cnt_d;
         row_w_q    <= row_w_d;
         prev_w_q   <= prev_w_d;
         inc_q      <= inc_d;
         dec_q      <= dec_d;
         flat_q     <= flat_d;
         row_end_q  <= row_end_d;
         color_q    <= color_d;
         shape_q    <= shape_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.COLOR        = color_q;
   assign bus.SHAPE        = shape_q;
   assign bus.RESULT_VALID = valid_q;
endmodule
